// File: rtl/reg_dump_uart_tx.sv
// Register-file dump engine: walks show_index over 0..NUM_REGS-1 and sends each
// captured 32-bit value as four 8N1 UART bytes, MSB byte first, on tx.
module reg_dump_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] Register_return,
  output logic [4:0]  show_index,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CAPTURE, S_START, S_DATA, S_STOP, S_DONE
  } state_t;

  state_t        r_state;
  logic [31:0]   r_word;
  logic [6:0]    r_shift;
  logic [1:0]    r_byte_cnt;
  logic [2:0]    r_bit_cnt;
  logic [CW-1:0] r_clk_cnt;
  logic [4:0]    r_idx;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;

  logic [7:0]    w_byte;
  logic          w_bit_end;

  always_comb begin
    w_byte = r_word[31:24];
    case (r_byte_cnt)
      2'd0:    w_byte = r_word[31:24];
      2'd1:    w_byte = r_word[23:16];
      2'd2:    w_byte = r_word[15:8];
      default: w_byte = r_word[7:0];
    endcase
  end

  assign w_bit_end = (r_clk_cnt == LAST_CLK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_bit_cnt  <= '0;
      r_clk_cnt  <= '0;
      r_idx      <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_SELECT;
            r_busy  <= 1'b1;
            r_idx   <= '0;
          end
        end
        S_SELECT: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_word     <= Register_return;
          r_byte_cnt <= '0;
          r_clk_cnt  <= '0;
          r_tx       <= 1'b0;
          r_state    <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= w_byte[7:1];
            r_tx      <= w_byte[0];
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[6:1]};
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            // Explicit compares end the walk; neither counter is allowed to wrap.
            if (r_byte_cnt != 2'd3) begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else if (r_idx != LAST_IDX) begin
              r_idx   <= r_idx + 5'd1;
              r_state <= S_SELECT;
            end else begin
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign show_index = r_idx;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
